gain_scale_sched: RTL and testbench

Two-requester scheduler that shares one fixed-point gain datapath between the left and right audio channels of the effector. The datapath sign-extends each sample 16→32, multiplies it by a Q8.8 gain, arithmetic-shifts right by DP and saturates back to 16 bits. The block arbitrates round-robin between channels and runs a 2-stage pipeline with a downstream hold. It sits between the ADC-read path and the DAC-write path.

---
 rtl/gain_scale_sched.sv | 121 ++++++++++++
 tb/tb_gain_scale_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gain_scale_sched.sv
// Two-channel round-robin scheduler feeding one shared Q8.8 gain datapath.
// Stage 1 latches the granted sample and gain; stage 2 multiplies, shifts and saturates.
module gain_scale_sched #(
  parameter int WS = 16,
  parameter int DP = 8
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iREQ_L,
  input  logic [WS-1:0] iDATA_L,
  output logic          oACK_L,
  input  logic          iREQ_R,
  input  logic [WS-1:0] iDATA_R,
  output logic          oACK_R,
  input  logic [WS-1:0] iGAIN,
  input  logic          iHOLD,
  output logic          oVALID,
  output logic [WS-1:0] oDATA,
  output logic          oCH,
  output logic          oSAT
);

  localparam int PW = 2 * WS;

  localparam logic signed [PW-1:0] C_QMAX = {{(PW-WS+1){1'b0}}, {(WS-1){1'b1}}};
  localparam logic signed [PW-1:0] C_QMIN = {{(PW-WS+1){1'b1}}, {(WS-1){1'b0}}};
  localparam logic [WS-1:0]        C_POS_SAT = {1'b0, {(WS-1){1'b1}}};
  localparam logic [WS-1:0]        C_NEG_SAT = {1'b1, {(WS-1){1'b0}}};

  logic              w_req [2];
  logic              w_gnt [2];
  logic              w_free;
  logic              w_xfer;
  logic [WS-1:0]     w_data_sel;

  logic              r_ptr;
  logic              r_v1;
  logic signed [PW-1:0] r_s;
  logic signed [PW-1:0] r_g;
  logic              r_ch;

  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_q;
  logic [WS-1:0]     w_res;
  logic              w_clip;

  logic              r_valid;
  logic [WS-1:0]     r_data;
  logic              r_och;
  logic              r_sat;

  assign w_req[0] = iREQ_L;
  assign w_req[1] = iREQ_R;
  assign w_free   = !iRST && !iHOLD;

  // A channel wins if it requests and either the other is idle or the pointer names it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      assign w_gnt[gi] = w_free && w_req[gi] && (!w_req[1-gi] || (r_ptr == 1'(gi)));
    end
  endgenerate

  assign oACK_L     = w_gnt[0];
  assign oACK_R     = w_gnt[1];
  assign w_xfer     = w_gnt[0] || w_gnt[1];
  assign w_data_sel = w_gnt[1] ? iDATA_R : iDATA_L;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_ptr <= 1'b0;
      r_v1  <= 1'b0;
      r_s   <= '0;
      r_g   <= '0;
      r_ch  <= 1'b0;
    end else if (!iHOLD) begin
      r_v1 <= w_xfer;
      if (w_xfer) begin
        r_s   <= {{(PW-WS){w_data_sel[WS-1]}}, w_data_sel};
        r_g   <= {{(PW-WS){iGAIN[WS-1]}}, iGAIN};
        r_ch  <= w_gnt[1];
        r_ptr <= ~w_gnt[1];
      end
    end
  end

  // The full WS x WS product fits in PW bits, so no intermediate overflow.
  assign w_p = r_s * r_g;
  assign w_q = w_p >>> DP;

  always_comb begin
    w_res  = w_q[WS-1:0];
    w_clip = 1'b0;
    if (w_q > C_QMAX) begin
      w_res  = C_POS_SAT;
      w_clip = 1'b1;
    end else if (w_q < C_QMIN) begin
      w_res  = C_NEG_SAT;
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_och   <= 1'b0;
      r_sat   <= 1'b0;
    end else if (!iHOLD) begin
      r_valid <= r_v1;
      r_data  <= w_res;
      r_och   <= r_ch;
      r_sat   <= w_clip;
    end
  end

  assign oVALID = r_valid;
  assign oDATA  = r_data;
  assign oCH    = r_och;
  assign oSAT   = r_sat;

endmodule

// File: tb/tb_gain_scale_sched.sv
// Bench for gain_scale_sched: queue-based reference model checked every cycle,
// plus directed transfers with literal expected results.
module tb_gain_scale_sched;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iREQ_L, iREQ_R, iHOLD;
  logic [15:0] iDATA_L, iDATA_R, iGAIN;
  logic        oACK_L, oACK_R, oVALID, oCH, oSAT;
  logic [15:0] oDATA;

  int n_chk  = 0;
  int n_fail = 0;

  gain_scale_sched #(.WS(16), .DP(8)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iREQ_L(iREQ_L), .iDATA_L(iDATA_L), .oACK_L(oACK_L),
    .iREQ_R(iREQ_R), .iDATA_R(iDATA_R), .oACK_R(oACK_R),
    .iGAIN(iGAIN), .iHOLD(iHOLD),
    .oVALID(oVALID), .oDATA(oDATA), .oCH(oCH), .oSAT(oSAT)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scale by Q8.8 gain with floor division and clip to 16 bits.
  function automatic logic [15:0] f_scale(input logic [15:0] d, input logic [15:0] g,
                                          output logic sat);
    longint p, q;
    p = longint'($signed(d)) * longint'($signed(g));
    q = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
    sat = 1'b1;
    if (q > 32767)  return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    sat = 1'b0;
    return 16'(q);
  endfunction

  typedef struct {
    logic [15:0] d;
    logic        ch;
    logic        sat;
    int          cnt;
  } ent_t;

  ent_t m_q[$];
  logic m_ptr      = 1'b0;
  bit   m_live     = 1'b0;
  bit   m_rst_seen = 1'b0;

  // Reference model: each accepted sample needs two non-held edges to become visible.
  always @(negedge iCLK) begin
    logic e_l, e_r, e_v, s;
    ent_t n;
    if (m_live) begin
      e_v = (m_q.size() > 0) && (m_q[0].cnt == 0);
      chk("oVALID", 32'(oVALID), 32'(e_v));
      if (e_v) begin
        chk("oDATA", 32'(oDATA), 32'(m_q[0].d));
        chk("oCH", 32'(oCH), 32'(m_q[0].ch));
        chk("oSAT", 32'(oSAT), 32'(m_q[0].sat));
      end
      if (m_rst_seen) begin
        chk("rst_oDATA", 32'(oDATA), 32'h0);
        chk("rst_oCH", 32'(oCH), 32'h0);
        chk("rst_oSAT", 32'(oSAT), 32'h0);
      end
    end
    e_l = !iRST && !iHOLD && iREQ_L && (!iREQ_R || m_ptr == 1'b0);
    e_r = !iRST && !iHOLD && iREQ_R && (!iREQ_L || m_ptr == 1'b1);
    if (m_live || iRST) begin
      chk("oACK_L", 32'(oACK_L), 32'(e_l));
      chk("oACK_R", 32'(oACK_R), 32'(e_r));
    end
    if (iRST) begin
      m_q.delete();
      m_ptr      = 1'b0;
      m_live     = 1'b1;
      m_rst_seen = 1'b1;
    end else begin
      m_rst_seen = 1'b0;
      if (!iHOLD) begin
        if (m_q.size() > 0 && m_q[0].cnt == 0) begin
          $display("out ch=%0d data=%h sat=%0d t=%0t", m_q[0].ch, m_q[0].d, m_q[0].sat, $time);
          void'(m_q.pop_front());
        end
        foreach (m_q[i]) m_q[i].cnt--;
        if (e_l || e_r) begin
          n.d   = f_scale(e_r ? iDATA_R : iDATA_L, iGAIN, s);
          n.sat = s;
          n.ch  = e_r;
          n.cnt = 1;
          m_q.push_back(n);
          m_ptr = e_l ? 1'b1 : 1'b0;
        end
      end
    end
  end

  // Single transfer on one channel with literal expectations two edges later.
  task automatic send_one(input string nm, input logic ch, input logic [15:0] d,
                          input logic [15:0] g, input logic [15:0] exp_d, input logic exp_s);
    @(posedge iCLK); #1;
    iREQ_L = !ch; iREQ_R = ch;
    if (ch) iDATA_R = d; else iDATA_L = d;
    iGAIN = g;
    #1;
    chk({nm, "_ack"}, 32'(ch ? oACK_R : oACK_L), 32'h1);
    @(posedge iCLK); #1;
    iREQ_L = 1'b0; iREQ_R = 1'b0;
    iGAIN  = 16'h5A5A;
    chk({nm, "_notyet"}, 32'(oVALID), 32'h0);
    @(posedge iCLK); #1;
    chk({nm, "_valid"}, 32'(oVALID), 32'h1);
    chk({nm, "_data"}, 32'(oDATA), 32'(exp_d));
    chk({nm, "_ch"}, 32'(oCH), 32'(ch));
    chk({nm, "_sat"}, 32'(oSAT), 32'(exp_s));
  endtask

  logic [15:0] gain_tab [8] = '{16'h0100, 16'h0080, 16'h0200, 16'hFF00,
                                16'h0040, 16'h0300, 16'h0100, 16'hFE80};
  logic [15:0] nxt_l = 16'h0100;
  logic [15:0] nxt_r = 16'hF000;
  int          step_n = 0;

  // One cycle with both channels free-running; data advances only after an ack.
  task automatic step_both();
    logic a_l, a_r;
    #1;
    a_l = oACK_L; a_r = oACK_R;
    @(posedge iCLK); #1;
    step_n++;
    iGAIN = gain_tab[step_n % 8];
    if (a_l) begin nxt_l = nxt_l + 16'h0731; iDATA_L = nxt_l; end
    if (a_r) begin nxt_r = nxt_r - 16'h0523; iDATA_R = nxt_r; end
  endtask

  initial begin
    iRST = 1'b1; iHOLD = 1'b0; iREQ_L = 1'b0; iREQ_R = 1'b0;
    iDATA_L = '0; iDATA_R = '0; iGAIN = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("reset_oVALID", 32'(oVALID), 32'h0);
    chk("reset_oDATA", 32'(oDATA), 32'h0);
    chk("reset_acks", 32'({oACK_L, oACK_R}), 32'h0);
    iRST = 1'b0;

    send_one("unity_L", 1'b0, 16'd10000, 16'h0100, 16'h2710, 1'b0);
    send_one("unity_R", 1'b1, 16'hD8F0, 16'h0100, 16'hD8F0, 1'b0);
    send_one("half_pos", 1'b0, 16'd10000, 16'h0080, 16'h1388, 1'b0);
    send_one("half_neg", 1'b1, 16'hFFFD, 16'h0080, 16'hFFFE, 1'b0);
    send_one("sat_pos", 1'b0, 16'd10000, 16'h0400, 16'h7FFF, 1'b1);
    send_one("sat_neg", 1'b1, 16'hD8F0, 16'h0400, 16'h8000, 1'b1);
    send_one("sat_min2", 1'b0, 16'h8000, 16'h8000, 16'h7FFF, 1'b1);

    // Both channels requesting continuously from reset.
    @(posedge iCLK); #1;
    iRST = 1'b1;
    iREQ_L = 1'b1; iREQ_R = 1'b1;
    iDATA_L = nxt_l; iDATA_R = nxt_r; iGAIN = gain_tab[0];
    @(posedge iCLK); #1;
    iRST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("alt_ack_L", 32'(oACK_L), 32'((i % 2) == 0));
      chk("alt_ack_R", 32'(oACK_R), 32'((i % 2) == 1));
      step_both();
    end

    // Stall with the pipeline full.
    iHOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_acks", 32'({oACK_L, oACK_R}), 32'h0);
      chk("hold_valid", 32'(oVALID), 32'h1);
      step_both();
    end
    iHOLD = 1'b0;
    repeat (4) step_both();

    // One-cycle reset with samples in flight.
    iRST = 1'b1;
    step_both();
    iRST = 1'b0;
    chk("post_rst_valid", 32'(oVALID), 32'h0);
    #1;
    chk("post_rst_ack_L", 32'(oACK_L), 32'h1);
    chk("post_rst_ack_R", 32'(oACK_R), 32'h0);
    repeat (4) step_both();

    iREQ_L = 1'b0; iREQ_R = 1'b0;
    repeat (4) @(posedge iCLK);
    #1;
    chk("drained_valid", 32'(oVALID), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
